// File: rtl/vector_add_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// vector_add_issue_ctrl_if
// Bundles the data-path handshakes around the vector_add issue controller:
//   s_a_*  : operand A stream (valid/ready/data)
//   s_b_*  : operand B stream (valid/ready/data)
//   add_*  : issue port to the fixed-latency adder array and its result return
//   m_*    : result stream (valid/ready/data)
// Modports:
//   slave  : the controller's view (consumes operands, drives the adder, sources results)
//   master : the surrounding environment's view (the mirror image)
// ----------------------------------------------------------------------------
interface vector_add_issue_ctrl_if #(
    parameter int DATA_W = 512
);
    logic              s_a_valid;
    logic              s_a_ready;
    logic [DATA_W-1:0] s_a_data;

    logic              s_b_valid;
    logic              s_b_ready;
    logic [DATA_W-1:0] s_b_data;

    logic [DATA_W-1:0] add_vector_1;
    logic [DATA_W-1:0] add_vector_2;
    logic              add_input_valid;
    logic              add_output_valid;
    logic [DATA_W-1:0] add_vector;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport slave (
        input  s_a_valid, s_a_data,
        output s_a_ready,
        input  s_b_valid, s_b_data,
        output s_b_ready,
        output add_vector_1, add_vector_2, add_input_valid,
        input  add_output_valid, add_vector,
        output m_valid, m_data,
        input  m_ready
    );

    modport master (
        output s_a_valid, s_a_data,
        input  s_a_ready,
        output s_b_valid, s_b_data,
        input  s_b_ready,
        input  add_vector_1, add_vector_2, add_input_valid,
        output add_output_valid, add_vector,
        input  m_valid, m_data,
        output m_ready
    );
endinterface

// File: rtl/vector_add_issue_ctrl.sv
// ----------------------------------------------------------------------------
// vector_add_issue_ctrl
// Control stage around the 16-lane FP32 vector_add array. Pairs the A and B
// operand streams, issues matched pairs to the adder through a register stage,
// and catches results in a first-word-fall-through FIFO. Issue is gated by a
// credit check so every result in flight is guaranteed a FIFO slot, because
// the adder cannot be stalled. A start/done handshake counts one instruction
// of cfg_num vector pairs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, cfg_num  begin an instruction of cfg_num pairs (ignored unless idle)
//   done            one-cycle pulse after the instruction's last result is popped
//   busy            high whenever an instruction is active
//   err_overflow    sticky: result arrived with the FIFO full and no pop
//   err_unexpected  sticky: result arrived with nothing in flight
//   bus             operand streams, adder port and result stream (slave view)
// ----------------------------------------------------------------------------
module vector_add_issue_ctrl #(
    parameter int DATA_W      = 512,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADD_LATENCY = 11,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_num,
    output logic                 done,
    output logic                 busy,
    output logic                 err_overflow,
    output logic                 err_unexpected,
    vector_add_issue_ctrl_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam int OCC_W   = FCNT_W + 1;
    localparam int FLUSH_W = $clog2(ADD_LATENCY + 2);

    localparam logic [FCNT_W-1:0]  DEPTH_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [FLUSH_W-1:0] FLUSH_LD  = FLUSH_W'(ADD_LATENCY);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE = FLUSH_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FCNT_W-1:0]  FCNT_ONE  = FCNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   popped_target;
    logic [CNT_W-1:0]   pop_cnt;
    logic [FCNT_W-1:0]  in_flight;
    logic [FCNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic [DATA_W-1:0]  vec_1_q;
    logic [DATA_W-1:0]  vec_2_q;
    logic               issue_q;

    logic [OCC_W-1:0]   occupancy;
    logic               credit_ok;
    logic               issue_window;
    logic               fire;
    logic               flushing;
    logic               res_accept;
    logic               res_unexp;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;

    // Results already promised to the FIFO plus results sitting in it must
    // never exceed its depth, since the adder has no way to stall.
    assign occupancy    = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok    = occupancy < DEPTH_OCC;
    assign issue_window = (state == RUN) && (remaining != '0) && credit_ok;
    assign fire         = issue_window && bus.s_a_valid && bus.s_b_valid;

    // Each ready looks only at the other stream's valid, so neither stream
    // is consumed unless its partner is present in the same cycle.
    assign bus.s_a_ready = issue_window && bus.s_b_valid;
    assign bus.s_b_ready = issue_window && bus.s_a_valid;

    // Results during the post-reset window belong to operations that the
    // reset aborted and are silently discarded.
    assign flushing   = (flush_cnt != '0);
    assign res_accept = bus.add_output_valid && !flushing && (in_flight != '0);
    assign res_unexp  = bus.add_output_valid && !flushing && (in_flight == '0);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign pop        = !fifo_empty && bus.m_ready;
    // A full FIFO can still take a result when the head leaves in the same cycle.
    assign push       = res_accept && (!fifo_full || pop);

    assign bus.m_valid         = !fifo_empty;
    assign bus.m_data          = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign bus.add_vector_1    = vec_1_q;
    assign bus.add_vector_2    = vec_2_q;
    assign bus.add_input_valid = issue_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = (cfg_num == '0) ? DONE : RUN;
            RUN:     if (remaining == '0) state_nxt = DRAIN;
            DRAIN:   if (pop_cnt == popped_target) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            remaining      <= '0;
            popped_target  <= '0;
            pop_cnt        <= '0;
            in_flight      <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            flush_cnt      <= FLUSH_LD;
            vec_1_q        <= '0;
            vec_2_q        <= '0;
            issue_q        <= 1'b0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            state <= state_nxt;

            if (flushing) flush_cnt <= flush_cnt - FLUSH_ONE;

            if ((state == IDLE) && start) begin
                remaining     <= cfg_num;
                popped_target <= cfg_num;
                pop_cnt       <= '0;
            end else begin
                if (fire) remaining <= remaining - CNT_ONE;
                if (pop)  pop_cnt   <= pop_cnt + CNT_ONE;
            end

            // A simultaneous issue and retire cancel out.
            case ({fire, res_accept})
                2'b10:   in_flight <= in_flight + FCNT_ONE;
                2'b01:   in_flight <= in_flight - FCNT_ONE;
                default: in_flight <= in_flight;
            endcase

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_ONE;
                2'b01:   fifo_count <= fifo_count - FCNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            issue_q <= fire;
            if (fire) begin
                vec_1_q <= bus.s_a_data;
                vec_2_q <= bus.s_b_data;
            end

            if (res_accept && fifo_full && !pop) err_overflow <= 1'b1;
            if (res_unexp) err_unexpected <= 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only ever read after
    // it has been written, and the empty FIFO drives zero on m_data.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.add_vector;
    end

endmodule

// File: tb/tb_vector_add_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vector_add_issue_ctrl
// Randomised bench for vector_add_issue_ctrl. A stand-in adder (fixed-latency
// delay line doing lane-wise FP32 adds) closes the loop. Expected results are
// the lane-wise sums of the i-th A and i-th B operand, in order; handshake
// rules (pairing, ready independence, credit limit) are checked per cycle.
// ----------------------------------------------------------------------------
module tb_vector_add_issue_ctrl;
    localparam int DATA_W      = 512;
    localparam int FIFO_DEPTH  = 16;
    localparam int ADD_LATENCY = 11;
    localparam int CNT_W       = 16;
    localparam int LANES       = DATA_W / 32;
    localparam int MAX_N       = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_num;
    logic             done;
    logic             busy;
    logic             err_overflow;
    logic             err_unexpected;
    logic             inject;

    vector_add_issue_ctrl_if #(.DATA_W(DATA_W)) bus ();

    vector_add_issue_ctrl #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADD_LATENCY(ADD_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_num       (cfg_num),
        .done          (done),
        .busy          (busy),
        .err_overflow  (err_overflow),
        .err_unexpected(err_unexpected),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- FP32 helpers (normal numbers only) ----------------
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        real         s;
        logic [63:0] d;
        logic [10:0] e;
        s = f32_to_real(a) + f32_to_real(b);
        d = $realtobits(s);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [DATA_W-1:0] vec_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*32 +: 32] = fp32_add(a[l*32 +: 32], b[l*32 +: 32]);
        return r;
    endfunction

    function automatic logic [31:0] rand_lane(input int tag);
        logic [31:0] w;
        int          e;
        w       = $urandom;
        e       = $urandom_range(120, 135);
        w[30:23] = e[7:0];
        w[7:0]   = tag[7:0];
        return w;
    endfunction

    // ---------------- stand-in adder: fixed-latency delay line ----------------
    logic [DATA_W-1:0] pipe_d [ADD_LATENCY] = '{default: '0};
    logic              pipe_v [ADD_LATENCY] = '{default: 1'b0};

    always @(posedge clk) begin
        pipe_v[0] <= bus.add_input_valid;
        pipe_d[0] <= vec_add(bus.add_vector_1, bus.add_vector_2);
        for (int i = 1; i < ADD_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign bus.add_output_valid = pipe_v[ADD_LATENCY-1] | inject;
    assign bus.add_vector       = pipe_d[ADD_LATENCY-1];

    // ---------------- operand tables ----------------
    logic [DATA_W-1:0] a_items [MAX_N];
    logic [DATA_W-1:0] b_items [MAX_N];

    task automatic fill_const(input logic [31:0] av, input logic [31:0] bv);
        for (int k = 0; k < MAX_N; k++) begin
            a_items[k] = {LANES{av}};
            b_items[k] = {LANES{bv}};
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < MAX_N; k++)
            for (int l = 0; l < LANES; l++) begin
                a_items[k][l*32 +: 32] = rand_lane(k);
                b_items[k][l*32 +: 32] = rand_lane(k + 128);
            end
    endtask

    // Results of the last run_instr for test-specific checks.
    int                r_first_fire, r_last_fire, r_first_mv, r_fires_at_hold;
    bit                r_ready_at_hold;
    logic [DATA_W-1:0] r_first_data;

    // One instruction of n pairs. b_skew delays B's first valid; gap_pct is
    // the chance a stream idles when it could present; m_ready is held low for
    // hold_cycles and then asserted with probability mready_pct.
    task automatic run_instr(input string name, input int n, input int b_skew, input int gap_pct,
                             input int mready_pct, input int hold_cycles, input bit poke_start);
        logic [DATA_W-1:0] exp_q [$];
        int ai = 0, bi = 0, pops = 0, fires = 0, cyc = 0, dones = 0;
        int done_cyc = -1, last_pop_cyc = -1;
        int pair_viol = 0, ready_viol = 0, credit_viol = 0, extra_pops = 0;
        int budget;
        bit a_v = 0, b_v = 0, a_hs, b_hs;

        budget          = 300 + n * 25 + hold_cycles;
        r_first_fire    = -1;
        r_last_fire     = -1;
        r_first_mv      = -1;
        r_fires_at_hold = -1;
        r_ready_at_hold = 0;
        r_first_data    = '0;
        for (int k = 0; k < n; k++) exp_q.push_back(vec_add(a_items[k], b_items[k]));

        @(negedge clk);
        cfg_num = CNT_W'(n);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (cyc < budget && !(dones > 0 && cyc > done_cyc + 3)) begin
            if (!a_v && ai < n && $urandom_range(0, 99) >= gap_pct) a_v = 1;
            if (!b_v && bi < n && cyc >= b_skew && $urandom_range(0, 99) >= gap_pct) b_v = 1;
            bus.s_a_valid = a_v;
            bus.s_a_data  = (a_v && ai < n) ? a_items[ai] : '0;
            bus.s_b_valid = b_v;
            bus.s_b_data  = (b_v && bi < n) ? b_items[bi] : '0;
            bus.m_ready   = (cyc < hold_cycles) ? 1'b0 : ($urandom_range(0, 99) < mready_pct);
            if (poke_start && cyc == 3) begin
                start   = 1'b1;
                cfg_num = CNT_W'(7);
            end else begin
                start   = 1'b0;
                cfg_num = CNT_W'(n);
            end
            #1;
            a_hs = bus.s_a_valid && bus.s_a_ready;
            b_hs = bus.s_b_valid && bus.s_b_ready;
            if (bus.s_a_ready && !bus.s_b_valid) ready_viol++;
            if (bus.s_b_ready && !bus.s_a_valid) ready_viol++;
            if (a_hs != b_hs) pair_viol++;
            if (a_hs && b_hs) begin
                if (ai != bi) pair_viol++;
                if (fires - pops >= FIFO_DEPTH) credit_viol++;
                if (r_first_fire < 0) r_first_fire = cyc;
                r_last_fire = cyc;
                fires++;
            end
            if (bus.m_valid && r_first_mv < 0) r_first_mv = cyc;
            if (bus.m_valid && bus.m_ready) begin
                if (pops < n) begin
                    if (pops == 0) r_first_data = bus.m_data;
                    check({name, "_data"}, bus.m_data, exp_q[pops]);
                end else begin
                    extra_pops++;
                end
                pops++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (cyc == hold_cycles - 1) begin
                r_fires_at_hold = fires;
                r_ready_at_hold = bus.s_a_ready || bus.s_b_ready;
            end
            if (a_hs) begin a_v = 0; ai++; end
            if (b_hs) begin b_v = 0; bi++; end
            @(negedge clk);
            cyc++;
        end
        bus.s_a_valid = 1'b0;
        bus.s_b_valid = 1'b0;
        bus.m_ready   = 1'b0;
        start         = 1'b0;

        check({name, "_finished"}, (dones > 0), 1'b1);
        check({name, "_fires"}, fires, n);
        check({name, "_pops"}, pops, n);
        check({name, "_extra_pops"}, extra_pops, 0);
        check({name, "_done_count"}, dones, 1);
        check({name, "_done_after_last_pop"}, done_cyc - last_pop_cyc, 2);
        check({name, "_pairing"}, pair_viol, 0);
        check({name, "_ready_needs_other_valid"}, ready_viol, 0);
        check({name, "_credit"}, credit_viol, 0);
        check({name, "_err_overflow"}, err_overflow, 1'b0);
        check({name, "_err_unexpected"}, err_unexpected, 1'b0);
        check({name, "_idle_after"}, busy, 1'b0);
    endtask

    task automatic check_quiet_outputs(input string name);
        check({name, "_m_valid"}, bus.m_valid, 1'b0);
        check({name, "_m_data"}, bus.m_data, '0);
        check({name, "_add_input_valid"}, bus.add_input_valid, 1'b0);
        check({name, "_add_vector_1"}, bus.add_vector_1, '0);
        check({name, "_add_vector_2"}, bus.add_vector_2, '0);
        check({name, "_s_a_ready"}, bus.s_a_ready, 1'b0);
        check({name, "_s_b_ready"}, bus.s_b_ready, 1'b0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_err_overflow"}, err_overflow, 1'b0);
        check({name, "_err_unexpected"}, err_unexpected, 1'b0);
    endtask

    initial begin
        int fires, stale_seen, mv_seen;
        bit z_ready;

        rst           = 1'b1;
        start         = 1'b0;
        cfg_num       = '0;
        inject        = 1'b0;
        bus.s_a_valid = 1'b0;
        bus.s_a_data  = '0;
        bus.s_b_valid = 1'b0;
        bus.s_b_data  = '0;
        bus.m_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet_outputs("reset");
        repeat (ADD_LATENCY + 2) @(negedge clk);

        // Basic: 1.0 + 2.0 in every lane, full throughput.
        fill_const(32'h3F80_0000, 32'h4000_0000);
        run_instr("basic", 4, 0, 0, 100, 0, 1'b0);
        check("basic_sum_value", r_first_data, {LANES{32'h4040_0000}});
        check("basic_first_result_latency", r_first_mv - r_first_fire, 13);
        check("basic_back_to_back_issue", r_last_fire - r_first_fire, 3);

        // Backpressure: results held back until the credit limit stops issue.
        fill_random();
        run_instr("backpressure", 40, 0, 0, 100, 60, 1'b0);
        check("backpressure_fires_while_blocked", r_fires_at_hold, FIFO_DEPTH);
        check("backpressure_readys_low", r_ready_at_hold, 1'b0);

        // Stream skew with random gaps and random result backpressure.
        fill_random();
        run_instr("skew", 24, 5, 30, 70, 0, 1'b0);

        // A start pulse mid-instruction must not disturb the count.
        fill_random();
        run_instr("restart_ignored", 20, 0, 10, 80, 0, 1'b1);

        // Zero-length instruction.
        @(negedge clk);
        cfg_num = '0;
        start   = 1'b1;
        #1;
        check("zero_idle_before", busy, 1'b0);
        z_ready = bus.s_a_ready || bus.s_b_ready;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_done", done, 1'b1);
        check("zero_busy_in_done", busy, 1'b1);
        z_ready = z_ready || bus.s_a_ready || bus.s_b_ready;
        @(negedge clk);
        #1;
        check("zero_done_one_cycle", done, 1'b0);
        check("zero_idle_after", busy, 1'b0);
        check("zero_no_issue", bus.add_input_valid, 1'b0);
        check("zero_no_ready", z_ready, 1'b0);

        // A few fully random instructions.
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_instr("random", $urandom_range(1, 30), $urandom_range(0, 4), $urandom_range(0, 40),
                      $urandom_range(30, 100), 0, 1'b0);
        end

        // Reset in the middle of an instruction with results still in the adder.
        fill_const(32'h3F80_0000, 32'h4000_0000);
        @(negedge clk);
        cfg_num = CNT_W'(10);
        start   = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        bus.s_a_valid = 1'b1;
        bus.s_a_data  = a_items[0];
        bus.s_b_valid = 1'b1;
        bus.s_b_data  = b_items[0];
        bus.m_ready   = 1'b1;
        fires = 0;
        for (int c = 0; c < 20 && fires < 3; c++) begin
            #1;
            if (bus.s_a_valid && bus.s_a_ready && bus.s_b_ready) fires++;
            if (fires < 3) @(negedge clk);
        end
        check("midreset_three_fires", fires, 3);
        @(negedge clk);
        rst           = 1'b1;
        bus.s_a_valid = 1'b0;
        bus.s_b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet_outputs("midreset");
        stale_seen = 0;
        mv_seen    = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.add_output_valid) stale_seen++;
            if (bus.m_valid) mv_seen++;
            @(negedge clk);
            #1;
        end
        check("midreset_stale_results_arrived", stale_seen, 3);
        check("midreset_no_results_out", mv_seen, 0);
        check("midreset_err_overflow", err_overflow, 1'b0);
        check("midreset_err_unexpected", err_unexpected, 1'b0);

        // Stray adder result while idle, long after the flush window.
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        check("stray_err_unexpected", err_unexpected, 1'b1);
        check("stray_err_overflow", err_overflow, 1'b0);
        mv_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.m_valid) mv_seen++;
            @(negedge clk);
            #1;
        end
        check("stray_no_result", mv_seen, 0);
        check("stray_err_sticky", err_unexpected, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stray_err_cleared_by_reset", err_unexpected, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
